// File: rtl/regfile_pkg.sv
// Shared defaults and dump-state encoding for the register file slice.
package regfile_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Streams every register out as valid/ready beats; holds each beat stable under stall.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             dump_start,
  input  logic             dump_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic [AW-1:0]    load_addr_c,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  dump_state_e state;

  // Address of the register captured into the hold register at the next edge.
  always_comb begin
    load_addr_c = '0;
    if (state == SEND) load_addr_c = AW'(dump_addr + AW'(1));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= SEND;
            dump_addr  <= '0;
            dump_data  <= load_data;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (dump_addr == LAST) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_addr <= load_addr_c;
              dump_data <= load_data;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile.sv
// Two-read one-write register file with r0 hardwired to zero, write bypass and a dump port.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [AW-1:0]    load_addr_c;
  logic [WIDTH-1:0] load_data_c;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports forward same-cycle write data; address 0 always reads zero.
  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == '0) rdata_a = '0;
    else if (we && (waddr == raddr_a)) rdata_a = wdata;

    rdata_b = regs[raddr_b];
    if (raddr_b == '0) rdata_b = '0;
    else if (we && (waddr == raddr_b)) rdata_b = wdata;
  end

  // Dump loads see pre-edge storage only, never the bypass path.
  always_comb begin
    load_data_c = regs[load_addr_c];
    if (load_addr_c == '0) load_data_c = '0;
  end

  regfile_dump_fsm #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_dump (
    .clk        (clk),
    .clr        (clr),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .load_data  (load_data_c),
    .load_addr_c(load_addr_c),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: vector table, corner sequences and a random run against a model.
module tb_regfile;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clr, we, dump_start, dump_ready;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata_a, rdata_b, dump_data;
  logic          dump_valid, dump_busy, dump_done;
  logic [AW-1:0] dump_addr;

  int checks = 0;
  int fails  = 0;

  // Reference model: register array plus dump progress (0 idle, 1 sending, 2 finished)
  logic [W-1:0] mregs [D];
  int           mstate;
  int           mi;
  logic [W-1:0] mhold;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
  } vec_t;

  vec_t tbl [8];

  regfile #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .clr       (clr),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr_a   (raddr_a),
    .rdata_a   (rdata_a),
    .raddr_b   (raddr_b),
    .rdata_b   (rdata_b),
    .dump_start(dump_start),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mread(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we && waddr == a) return wdata;
    return mregs[a];
  endfunction

  task automatic check_all();
    chk("rdata_a", rdata_a, mread(raddr_a));
    chk("rdata_b", rdata_b, mread(raddr_b));
    chkb("dump_valid", dump_valid, mstate == 1);
    chkb("dump_busy", dump_busy, mstate != 0);
    chkb("dump_done", dump_done, mstate == 2);
    if (mstate == 1) begin
      chk("dump_addr", W'(dump_addr), W'(mi));
      chk("dump_data", dump_data, mhold);
    end
  endtask

  // Advance the model with the pre-edge inputs, then clock the DUT.
  task automatic tick();
    if (clr) begin
      mstate = 0;
      mi     = 0;
      mhold  = '0;
      for (int i = 0; i < D; i++) mregs[i] = '0;
    end else begin
      case (mstate)
        0: if (dump_start) begin mstate = 1; mi = 0; mhold = '0; end
        1: if (dump_ready) begin
             if (mi == D - 1) mstate = 2;
             else begin mi = mi + 1; mhold = mregs[mi]; end
           end
        default: mstate = 0;
      endcase
      if (we && waddr != 0) mregs[waddr] = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    #1;
    tick();

    // Reset state, and reset winning over a simultaneous write and dump request
    raddr_a = 5'd3;
    #1;
    chkb("rst_valid", dump_valid, 1'b0);
    chkb("rst_busy", dump_busy, 1'b0);
    chkb("rst_done", dump_done, 1'b0);
    chk("rst_addr", W'(dump_addr), '0);
    chk("rst_data", dump_data, '0);
    chk("rst_read", rdata_a, '0);
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0123; dump_start = 1'b1;
    tick();
    clr = 1'b0; we = 1'b0; dump_start = 1'b0; raddr_a = 5'd9;
    #1;
    chkb("prio_valid", dump_valid, 1'b0);
    chkb("prio_busy", dump_busy, 1'b0);
    chk("prio_read", rdata_a, '0);

    // Table of read/write vectors, each applied for one cycle
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    tbl[3] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    tbl[6] = '{1'b0, 5'd31, 32'h00000001, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[7] = '{1'b1, 5'd5,  32'h00000001, 5'd0,  5'd5,  32'h0,        32'h00000001};
    for (int v = 0; v < 8; v++) begin
      we = tbl[v].we; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
      raddr_a = tbl[v].ra; raddr_b = tbl[v].rb;
      #1;
      chk($sformatf("vec%0d_a", v), rdata_a, tbl[v].ea);
      chk($sformatf("vec%0d_b", v), rdata_b, tbl[v].eb);
      tick();
    end
    we = 1'b0;

    // Full dump with ready held high; a second start mid-dump must be ignored
    for (int i = 1; i < D; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = W'(i * 32'h11);
      tick();
    end
    we = 1'b0;
    dump_start = 1'b1; dump_ready = 1'b1;
    #1;
    chkb("start_cycle_valid", dump_valid, 1'b0);
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (i == 5) dump_start = 1'b1;
      #1;
      chkb($sformatf("beat%0d_valid", i), dump_valid, 1'b1);
      chk($sformatf("beat%0d_addr", i), W'(dump_addr), W'(i));
      chk($sformatf("beat%0d_data", i), dump_data, W'(i * 32'h11));
      chkb($sformatf("beat%0d_done", i), dump_done, 1'b0);
      tick();
      dump_start = 1'b0;
    end
    chkb("done_pulse", dump_done, 1'b1);
    chkb("done_busy", dump_busy, 1'b1);
    chkb("done_valid", dump_valid, 1'b0);
    tick();
    chkb("after_done", dump_done, 1'b0);
    chkb("after_busy", dump_busy, 1'b0);

    // Stall at beat 3 for four cycles while r3 is overwritten
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int n = 0; n < 50 && !(dump_valid && dump_addr == 5'd3); n++) tick();
    chkb("stall_reached", dump_valid && dump_addr == 5'd3, 1'b1);
    dump_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin we = 1'b1; waddr = 5'd3; wdata = 32'h0000FFFF; end
      #1;
      chkb($sformatf("stall%0d_valid", k), dump_valid, 1'b1);
      chk($sformatf("stall%0d_addr", k), W'(dump_addr), 32'd3);
      chk($sformatf("stall%0d_data", k), dump_data, 32'h33);
      tick();
      we = 1'b0;
    end
    dump_ready = 1'b1; raddr_a = 5'd3;
    #1;
    chk("stall_release_data", dump_data, 32'h33);
    chk("r3_new_value", rdata_a, 32'h0000FFFF);
    tick();
    chk("beat4_addr", W'(dump_addr), 32'd4);
    chk("beat4_data", dump_data, 32'h44);
    for (int n = 0; n < 100 && !dump_done; n++) tick();
    chkb("stall_dump_done", dump_done, 1'b1);
    tick();

    // Reset in the middle of a dump aborts it without a done pulse
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int n = 0; n < 50 && !(dump_valid && dump_addr == 5'd10); n++) tick();
    chkb("beat10_reached", dump_valid && dump_addr == 5'd10, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chkb("abort_valid", dump_valid, 1'b0);
    chkb("abort_busy", dump_busy, 1'b0);
    chkb("abort_done", dump_done, 1'b0);
    for (int a = 0; a < D; a++) begin
      raddr_a = AW'(a); raddr_b = AW'(D - 1 - a);
      #1;
      chk($sformatf("cleared_a%0d", a), rdata_a, '0);
      chk($sformatf("cleared_b%0d", a), rdata_b, '0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chkb($sformatf("abort_no_done%0d", k), dump_done, 1'b0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      we         = 1'($urandom % 2);
      waddr      = AW'($urandom);
      wdata      = $urandom;
      raddr_a    = ($urandom % 4 == 0) ? waddr : AW'($urandom);
      raddr_b    = ($urandom % 4 == 0) ? raddr_a : AW'($urandom);
      dump_ready = ($urandom % 4 != 0);
      dump_start = ($urandom % 16 == 0);
      clr        = ($urandom % 300 == 0);
      #1;
      check_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
